// File: rtl/enum_rr_arbiter_if.sv
// Request/response bundle for the enum round-robin arbiter.
// The slave modport faces the arbiter; the master modport faces the requesters and sink.
interface enum_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_value;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_value;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  logic                     err_illegal;
  logic [7:0]               err_count;

  modport slave (
    input  req_valid, req_value, out_ready,
    output req_ready, out_valid, out_value, out_src, err_illegal, err_count
  );

  modport master (
    output req_valid, req_value, out_ready,
    input  req_ready, out_valid, out_value, out_src, err_illegal, err_count
  );
endinterface

// File: rtl/enum_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry output stage with enum tokens (0..2).
// Illegal encodings are consumed, dropped, flagged for one cycle and counted (saturating).
module enum_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  enum_rr_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [SRC_W-1:0] ptr_reg, ptr_next;
  logic [SRC_W-1:0] src_reg, src_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             err_reg, err_next;
  logic [7:0]       cnt_reg, cnt_next;

  logic [WIDTH-1:0] val_arr [NUM_REQ];
  logic [SRC_W-1:0] win;
  logic [WIDTH-1:0] win_value;
  logic             any_valid;
  logic             accept_en;
  logic             accept;
  logic             legal;
  logic [NUM_REQ-1:0] ready_vec;

  // Unpack the flat value bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign val_arr[gi] = bus.req_value[gi*WIDTH +: WIDTH];
  end

  // Rotating priority search: first valid requester at or after ptr wins.
  always_comb begin
    int idx;
    win       = ptr_reg;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && bus.req_valid[SRC_W'(idx)]) begin
        any_valid = 1'b1;
        win       = SRC_W'(idx);
      end
    end
  end

  assign win_value = val_arr[win];
  assign legal     = (win_value <= WIDTH'(2));
  // A full stage can take a new token only in the cycle it is being drained.
  assign accept_en = (state_reg == EMPTY) || bus.out_ready;
  // Grant never looks at the token value, and is suppressed while in reset.
  assign accept    = !rst && accept_en && any_valid;

  // One-hot grant to the winner.
  always_comb begin
    ready_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept && (win == SRC_W'(k))) ready_vec[k] = 1'b1;
    end
  end

  // Next-state: drain, refill, pointer advance and illegal-token accounting.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    value_next = value_reg;
    src_next   = src_reg;
    err_next   = 1'b0;
    cnt_next   = cnt_reg;
    if ((state_reg == FULL) && bus.out_ready) state_next = EMPTY;
    if (accept) begin
      ptr_next = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
      if (legal) begin
        state_next = FULL;
        value_next = win_value;
        src_next   = win;
      end else begin
        err_next = 1'b1;
        if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
      end
    end
  end

  // State and output-stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      ptr_reg   <= '0;
      value_reg <= '0;
      src_reg   <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      value_reg <= value_next;
      src_reg   <= src_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.req_ready   = ready_vec;
  assign bus.out_valid   = (state_reg == FULL);
  assign bus.out_value   = value_reg;
  assign bus.out_src     = src_reg;
  assign bus.err_illegal = err_reg;
  assign bus.err_count   = cnt_reg;

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Bench for enum_rr_arbiter: hand-derived vector table, saturation sequence,
// then random traffic against a transaction-level reference model.
module tb_enum_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enum_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();
  enum_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  // Reference model: output stage contents, rr pointer, error status.
  int m_full, m_value, m_src, m_ptr, m_ill, m_cnt;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] vals;
    logic        o;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [1:0]  e_src;
    logic        e_ill;
    logic [7:0]  e_cnt;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int val_of(input int i);
    logic [31:0] vv;
    vv = bus.req_value;
    return int'(vv[i*8 +: 8]);
  endfunction

  // Winner = first valid index scanning ptr, ptr+1, ... modulo N; -1 if none.
  function automatic int model_win();
    logic [3:0] vld;
    vld = bus.req_valid;
    for (int k = 0; k < N; k++)
      if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int model_ready();
    int w;
    w = model_win();
    if (rst || w < 0 || !(m_full == 0 || bus.out_ready)) return 0;
    return 1 << w;
  endfunction

  task automatic model_reset();
    m_full = 0; m_value = 0; m_src = 0; m_ptr = 0; m_ill = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    int w, v;
    bit take;
    if (rst) begin
      model_reset();
      return;
    end
    w    = model_win();
    take = (w >= 0) && (m_full == 0 || bus.out_ready);
    m_ill = 0;
    if (m_full != 0 && bus.out_ready) m_full = 0;
    if (take) begin
      m_ptr = (w + 1) % N;
      v = val_of(w);
      if (v <= 2) begin
        m_full = 1; m_value = v; m_src = w;
      end else begin
        m_ill = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic check_model();
    chk("req_ready",   32'(bus.req_ready),   32'(model_ready()));
    chk("out_valid",   32'(bus.out_valid),   32'(m_full));
    chk("out_value",   32'(bus.out_value),   32'(m_value));
    chk("out_src",     32'(bus.out_src),     32'(m_src));
    chk("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
    chk("err_count",   32'(bus.err_count),   32'(m_cnt));
  endtask

  // Drive inputs after the rising edge, then sample at the falling edge.
  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] vals, input logic o);
    rst = r; bus.req_valid = v; bus.req_value = vals; bus.out_ready = o;
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    // Expected outputs at the sampling point of each cycle (registered fields reflect earlier cycles).
    // Test 1: all four requesters, legal values, sink always ready.
    tbl[0]  = '{1'b0, 4'b1111, 32'h00020100, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'b1111, 32'h00020100, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 4'b1111, 32'h00020100, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 4'b1111, 32'h00020100, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 4'b1111, 32'h00020100, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 8'd0};
    // Test 2: only req 2 valid, back-pressure, then same-cycle refill.
    tbl[6]  = '{1'b0, 4'b0100, 32'h00010000, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 4'b0100, 32'h00010000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 4'b0100, 32'h00010000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 4'b0100, 32'h00010000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd0};
    // Test 3: req 1 illegal (5), next grant to req 2.
    tbl[11] = '{1'b0, 4'b0110, 32'h00010500, 1'b1, 4'b0010, 1'b0, 2'd2, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 4'b0100, 32'h00010500, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 8'd1};
    tbl[13] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 8'd1};
    // Test 5: ptr=3, requesters 3 and 0 -> grant 3 then wrap to 0.
    tbl[14] = '{1'b0, 4'b1001, 32'h00000000, 1'b1, 4'b1000, 1'b0, 2'd2, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 4'b1001, 32'h00000000, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b0, 8'd1};
    tbl[16] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 8'd1};
    // Test 6: reset while FULL with all requesters valid.
    tbl[17] = '{1'b0, 4'b1111, 32'h00020100, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 8'd1};
    tbl[18] = '{1'b1, 4'b1111, 32'h00020100, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 8'd1};
    tbl[19] = '{1'b0, 4'b1111, 32'h00020100, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 8'd0};

    rst = 1'b1; bus.req_valid = '0; bus.req_value = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].vals, tbl[i].o);
      chk($sformatf("v%0d_ready", i),   32'(bus.req_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_valid", i),   32'(bus.out_valid),   32'(tbl[i].e_ov));
      chk($sformatf("v%0d_src", i),     32'(bus.out_src),     32'(tbl[i].e_src));
      chk($sformatf("v%0d_illegal", i), 32'(bus.err_illegal), 32'(tbl[i].e_ill));
      chk($sformatf("v%0d_count", i),   32'(bus.err_count),   32'(tbl[i].e_cnt));
      $display("vec %0d: valid=%b ready=%b out_valid=%b src=%0d err=%b cnt=%0d",
               i, tbl[i].v, bus.req_ready, bus.out_valid, bus.out_src, bus.err_illegal, bus.err_count);
      advance();
    end

    // Test 4: 260 back-to-back illegal tokens saturate the counter.
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1);
      if (i > 0) chk("sat_pulse", 32'(bus.err_illegal), 32'd1);
      advance();
    end
    drive(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("sat_count", 32'(bus.err_count), 32'd255);
    chk("sat_last_pulse", 32'(bus.err_illegal), 32'd1);
    chk("sat_out_valid", 32'(bus.out_valid), 32'd0);
    $display("saturation: err_count=%0d after 260 illegal tokens", bus.err_count);
    advance();
    drive(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("sat_pulse_clear", 32'(bus.err_illegal), 32'd0);
    advance();

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] vals;
      logic [3:0]  v;
      for (int r = 0; r < N; r++)
        vals[r*8 +: 8] = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 2))
                                                     : 8'($urandom_range(3, 255));
      v = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) == 0), v, vals, 1'($urandom_range(0, 1)));
      if (i % 100 == 0)
        $display("rand %0d: valid=%b ready=%b out_valid=%b value=%0d src=%0d cnt=%0d",
                 i, v, bus.req_ready, bus.out_valid, bus.out_value, bus.out_src, bus.err_count);
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
